dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-cache port (addr/data_in/mode/write_en/read_en) between two requesters:
//  port 0 = core MEM stage, port 1 = DMA/debug. Round-robin arbitration, one transaction in flight,
//  misalignment check before issue, watchdog timeout on the cache side. Sits between MEM stage and dcache.
// PARAMETERS
//  XLEN     32   data/address width (matches `XLEN)
//  TIMEOUT  16   max BUSY cycles waiting for m_ready before error abort (>=2)
//  CNT_W    5    watchdog counter width, must hold TIMEOUT
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  pN_req     in   1     (N=0,1) request, held until pN_gnt
//  pN_we      in   1     1=store, 0=load
//  pN_mode    in   3     funct3-style size/sign: [1:0] 00=byte 01=half 10=word; [2]=unsigned load
//  pN_addr    in   XLEN  byte address
//  pN_wdata   in   XLEN  store data
//  pN_gnt     out  1     one-cycle pulse: request accepted, fields captured
//  pN_rvalid  out  1     one-cycle pulse: transaction complete
//  pN_err     out  1     qualifies pN_rvalid: misaligned or timeout
//  pN_rdata   out  XLEN  load data, valid with pN_rvalid
//  m_read_en  out  1     dcache read enable
//  m_write_en out  1     dcache write enable
//  m_mode     out  3     dcache mode
//  m_addr     out  XLEN  dcache address
//  m_wdata    out  XLEN  dcache write data
//  m_ready    in   1     dcache completion; m_rdata valid same cycle
//  m_rdata    in   XLEN  dcache read data
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last=1 (port 0 wins first), owner=0, all gnt/rvalid/err=0,
//   m_read_en=m_write_en=0, captured addr/wdata/mode/rdata regs=0, watchdog=0.
//  States IDLE, BUSY, RESP.
//  IDLE: no req -> stay. Any req -> winner = only requester, or if both, port != last.
//   Same cycle: winner gnt=1 (combinational from state+req), capture we/mode/addr/wdata, owner=winner,
//   last=winner. Misaligned (half & addr[0]; word & addr[1:0]!=0; mode[1:0]=11 is illegal, same handling)
//   -> RESP with err=1, no cache access. Else -> BUSY, watchdog=0.
//  BUSY: m_read_en=~we, m_write_en=we, m_* driven from captured regs only (stable whole state).
//   m_ready=1 -> capture m_rdata (0 if store), err=0, -> RESP.
//   else watchdog+1; watchdog==TIMEOUT-1 without m_ready -> err=1, -> RESP; enables drop on that edge.
//  RESP: owner rvalid=1 for exactly one cycle, rdata/err from regs; other port all zero; -> IDLE.
//  Latency: grant cycle T, m_ready at T+1 -> rvalid at T+2; earliest next grant T+3.
//  Requests arriving in BUSY/RESP wait; gnt never in BUSY/RESP. At most one gnt per cycle.
//  Round-robin fairness: with both held high, grants alternate 0,1,0,1...
//  Requester dropping req before gnt: nothing issued. Fields after gnt ignored.
//  m_ready outside BUSY: ignored. Reset mid-transaction: abandon, no rvalid, return to reset state.
// TESTING
//  1 Reset, p0 load word addr 0x100, m_ready at T+1 with 0xDEADBEEF -> p0_gnt@T, p0_rvalid@T+2, rdata 0xDEADBEEF, err=0.
//  2 p0,p1 both req continuously, 4 txns -> grant order p0,p1,p0,p1; no overlap of m_read_en/m_write_en.
//  3 p1 store half addr 0x203 -> p1_gnt, RESP next cycle with p1_err=1, m_write_en never asserted.
//  4 m_ready held 0 with TIMEOUT=16 -> enables high exactly 16 cycles, then p0_rvalid with err=1.
//  5 rst_n low during BUSY -> outputs 0 immediately; after release p0 granted first; no stale rvalid.
//  6 p0 store word addr 0x40 data 0x12345678, m_ready after 3 cycles -> m_addr/m_wdata stable all BUSY, rvalid rdata=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single dcache port.
// One transaction in flight; misaligned requests are answered without touching the cache.
module dmem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [2:0]      p0_mode,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic            p0_err,
  output logic [XLEN-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [2:0]      p1_mode,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic            p1_err,
  output logic [XLEN-1:0] p1_rdata,
  output logic            m_read_en,
  output logic            m_write_en,
  output logic [2:0]      m_mode,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ready,
  input  logic [XLEN-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic              last, owner;
  logic              we_q, err_q;
  logic [2:0]        mode_q;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]  wdog;

  logic              any_req, win, sel_we, misalign, wd_exp;
  logic [2:0]        sel_mode;
  logic [XLEN-1:0]   sel_addr, sel_wdata;

  // Contention goes to the port that did not win last time.
  assign any_req   = p0_req | p1_req;
  assign win       = (p0_req & p1_req) ? ~last : p1_req;
  assign sel_we    = win ? p1_we    : p0_we;
  assign sel_mode  = win ? p1_mode  : p0_mode;
  assign sel_addr  = win ? p1_addr  : p0_addr;
  assign sel_wdata = win ? p1_wdata : p0_wdata;
  assign wd_exp    = (wdog == CNT_W'(TIMEOUT-1));

  always_comb begin
    misalign = 1'b0;
    case (sel_mode[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = sel_addr[0];
      2'b10:   misalign = |sel_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        p0_gnt    = ~win;
        p1_gnt    = win;
        state_nxt = misalign ? RESP : BUSY;
      end
      BUSY: if (m_ready || wd_exp) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wdog    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          owner   <= win;
          last    <= win;
          we_q    <= sel_we;
          mode_q  <= sel_mode;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          err_q   <= misalign;
          rdata_q <= '0;
          wdog    <= '0;
        end
        BUSY: begin
          if (m_ready) begin
            rdata_q <= we_q ? '0 : m_rdata;
            err_q   <= 1'b0;
          end else if (wd_exp) begin
            err_q <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Cache side is driven only from captured fields so it cannot move while BUSY.
  assign m_read_en  = (state == BUSY) & ~we_q;
  assign m_write_en = (state == BUSY) & we_q;
  assign m_mode     = mode_q;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;

  assign p0_rvalid = (state == RESP) & ~owner;
  assign p1_rvalid = (state == RESP) & owner;
  assign p0_err    = p0_rvalid & err_q;
  assign p1_err    = p1_rvalid & err_q;
  assign p0_rdata  = p0_rvalid ? rdata_q : '0;
  assign p1_rdata  = p1_rvalid ? rdata_q : '0;
endmodule
